program_counter_unit: RTL and testbench

PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

---
 rtl/pcu_pkg.sv | 16 +
 rtl/pcu_incrementer.sv | 12 +
 rtl/program_counter_unit.sv | 121 ++++++++++++
 tb/tb_program_counter_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcu_pkg.sv
// Shared types and default configuration for the program counter unit.
package pcu_pkg;

  localparam int PCU_WIDTH         = 16;
  localparam int PCU_SETTLE_CYCLES = 1;
  // Wide enough for the largest allowed settle count (15).
  localparam int PCU_CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETTLE    = 2'd1,
    LATCH_INC = 2'd2,
    LATCH_PC  = 2'd3
  } pcu_state_e;

endpackage

// File: rtl/pcu_incrementer.sv
// Combinational WIDTH-bit +1 with carry-out of the top bit.
module pcu_incrementer #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + (WIDTH+1)'(1);

endmodule

// File: rtl/program_counter_unit.sv
// Program counter with a multi-cycle increment sequence (settle, latch
// incrementer into inc_reg, copy inc_reg back to pc) and single-cycle load.
// Optional feature macro: PCU_WRAP_FLAG_EN enables the wrap pulse; when it
// is undefined the wrap port is tied low and no carry is captured.
module program_counter_unit
  import pcu_pkg::*;
#(
  parameter int WIDTH         = PCU_WIDTH,
  parameter int SETTLE_CYCLES = PCU_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_req,
  input  logic             load_req,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] inc_reg,
  output logic             sel_pc,
  output logic             sel_inc,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  pcu_state_e             state_q, state_d;
  logic [PCU_CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]       inc_sum;
  logic                   inc_carry;

  // The incrementer always sees pc; sel_pc marks when that bus is valid.
  pcu_incrementer #(.WIDTH(WIDTH)) u_inc (
    .a     (pc),
    .sum   (inc_sum),
    .carry (inc_carry)
  );

  assign busy = (state_q != IDLE);

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and bus-select decode. Load beats increment in IDLE.
  always_comb begin
    state_d = state_q;
    sel_pc  = 1'b0;
    sel_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (!load_req && inc_req) state_d = SETTLE;
      end
      SETTLE: begin
        sel_pc = 1'b1;
        if (cnt_q == '0) state_d = LATCH_INC;
      end
      LATCH_INC: begin
        sel_pc  = 1'b1;
        state_d = LATCH_PC;
      end
      LATCH_PC: begin
        sel_inc = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: pc, inc_reg, settle counter and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      inc_reg <= '0;
      cnt_q   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_req) begin
            pc   <= load_data;
            done <= 1'b1;
          end else if (inc_req) begin
            cnt_q <= PCU_CNT_W'(SETTLE_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        LATCH_INC: inc_reg <= inc_sum;
        LATCH_PC: begin
          pc   <= inc_reg;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PCU_WRAP_FLAG_EN
  logic carry_q;

  // Carry is captured with inc_reg and reported alongside done.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (state_q == LATCH_INC) carry_q <= inc_carry;
      if (state_q == LATCH_PC)  wrap    <= carry_q;
    end
  end
`else
  logic unused_carry;
  assign unused_carry = inc_carry;
  assign wrap         = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter_unit.sv
// Scoreboard bench: two instances (settle 1 and settle 4). Each accepted
// request pushes its expected completion; a negedge monitor pops on done.
module tb_program_counter_unit;

  localparam int W   = 16;
  localparam int S_A = 1;
  localparam int S_B = 4;
`ifdef PCU_WRAP_FLAG_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef struct {
    int         dut;
    logic [W-1:0] pc;
    logic [W-1:0] inc;
    logic       wrap;
    int         due;
    int         npc;
    int         ninc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     inc_i, load_i;
  logic [W-1:0]   data_i [2];
  logic [W-1:0]   pc_o [2];
  logic [W-1:0]   incr_o [2];
  logic [1:0]     sel_pc_o, sel_inc_o, busy_o, done_o, wrap_o;

  int             cyc = 0;
  int             n_chk = 0;
  int             n_pass = 0;
  exp_t           sbq[$];
  logic [W-1:0]   mpc [2];
  logic [W-1:0]   minc [2];
  int             npc [2];
  int             ninc [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  program_counter_unit #(.WIDTH(W), .SETTLE_CYCLES(S_A)) dut_a (
    .clk(clk), .reset(rst), .inc_req(inc_i[0]), .load_req(load_i[0]),
    .load_data(data_i[0]), .pc(pc_o[0]), .inc_reg(incr_o[0]),
    .sel_pc(sel_pc_o[0]), .sel_inc(sel_inc_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .wrap(wrap_o[0])
  );

  program_counter_unit #(.WIDTH(W), .SETTLE_CYCLES(S_B)) dut_b (
    .clk(clk), .reset(rst), .inc_req(inc_i[1]), .load_req(load_i[1]),
    .load_data(data_i[1]), .pc(pc_o[1]), .inc_reg(incr_o[1]),
    .sel_pc(sel_pc_o[1]), .sel_inc(sel_inc_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .wrap(wrap_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_inc(input int d, input int s);
    exp_t e;
    logic [W:0] sum;
    sum    = {1'b0, mpc[d]} + 17'd1;
    e.dut  = d;
    e.pc   = sum[W-1:0];
    e.inc  = sum[W-1:0];
    e.wrap = WRAP_EN & sum[W];
    e.due  = cyc + s + 3;
    e.npc  = s + 1;
    e.ninc = 1;
    sbq.push_back(e);
    mpc[d]  = sum[W-1:0];
    minc[d] = sum[W-1:0];
  endtask

  task automatic push_load(input int d, input logic [W-1:0] v);
    exp_t e;
    e.dut  = d;
    e.pc   = v;
    e.inc  = minc[d];
    e.wrap = 1'b0;
    e.due  = cyc + 1;
    e.npc  = 0;
    e.ninc = 0;
    sbq.push_back(e);
    mpc[d] = v;
  endtask

  // Entered and left just after a rising edge; leaves in the done cycle.
  task automatic do_load(input int d, input logic [W-1:0] v, input logic with_inc);
    load_i[d] = 1'b1;
    inc_i[d]  = with_inc;
    data_i[d] = v;
    push_load(d, v);
    step();
    load_i[d] = 1'b0;
    inc_i[d]  = 1'b0;
  endtask

  task automatic do_inc(input int d, input int s);
    inc_i[d] = 1'b1;
    push_inc(d, s);
    step();
    inc_i[d] = 1'b0;
    repeat (s + 2) step();
  endtask

  // Monitor: exclusivity every cycle, scoreboard pop on each done pulse.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("sel_excl", 32'(sel_pc_o[d] & sel_inc_o[d]), 0);
      if (rst) begin
        npc[d]  = 0;
        ninc[d] = 0;
      end else if (done_o[d]) begin
        if (sbq.size() == 0 || sbq[0].dut != d) begin
          chk("spurious_done", 32'(done_o[d]), 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("pc", 32'(pc_o[d]), 32'(e.pc));
          chk("inc_reg", 32'(incr_o[d]), 32'(e.inc));
          chk("wrap", 32'(wrap_o[d]), 32'(e.wrap));
          chk("sel_pc_cycles", npc[d], e.npc);
          chk("sel_inc_cycles", ninc[d], e.ninc);
        end
        npc[d]  = 0;
        ninc[d] = 0;
      end else begin
        npc[d]  += 32'(sel_pc_o[d]);
        ninc[d] += 32'(sel_inc_o[d]);
      end
    end
    if (sbq.size() != 0 && cyc > sbq[0].due) begin
      chk("done_missing", 0, 1);
      void'(sbq.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    inc_i  = '0;
    load_i = '0;
    data_i[0] = '0;
    data_i[1] = '0;
    for (int d = 0; d < 2; d++) begin
      mpc[d] = '0; minc[d] = '0; npc[d] = 0; ninc[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", 32'(pc_o[0]), 0);
    chk("rst_inc_reg", 32'(incr_o[0]), 0);
    chk("rst_sel_pc", 32'(sel_pc_o[0]), 0);
    chk("rst_sel_inc", 32'(sel_inc_o[0]), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_wrap", 32'(wrap_o), 0);
    chk("rst_pc_b", 32'(pc_o[1]), 0);
    step();

    // First request presented together with reset release.
    rst = 1'b0;
    do_inc(0, S_A);

    // Load and increment in the same cycle: load wins.
    do_load(0, 16'h1234, 1'b1);
    @(negedge clk);
    chk("load_no_inc_busy", 32'(busy_o[0]), 0);
    chk("load_no_inc_pc", 32'(pc_o[0]), 32'h1234);
    step();
    chk("load_no_inc_busy2", 32'(busy_o[0]), 0);

    // Wrap from all-ones.
    do_load(0, 16'hFFFF, 1'b0);
    do_inc(0, S_A);

    // Held inc_req: back-to-back increments across a byte boundary.
    do_load(0, 16'h00FE, 1'b0);
    inc_i[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      push_inc(0, S_A);
      repeat (S_A + 3) @(posedge clk);
      #1;
    end
    inc_i[0] = 1'b0;

    // A few random loads each followed by an increment.
    for (int j = 0; j < 4; j++) begin
      do_load(0, W'($urandom), 1'b0);
      do_inc(0, S_A);
    end

    // Reset while in LATCH_INC aborts the increment.
    do_load(0, 16'h5555, 1'b0);
    do_inc(0, S_A);
    inc_i[0] = 1'b1;
    step();
    inc_i[0] = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_sel_pc", 32'(sel_pc_o[0]), 1);
    chk("mid_busy", 32'(busy_o[0]), 1);
    step();
    rst = 1'b0;
    mpc[0]  = '0;
    minc[0] = '0;
    @(negedge clk);
    chk("abort_pc", 32'(pc_o[0]), 0);
    chk("abort_inc_reg", 32'(incr_o[0]), 0);
    chk("abort_busy", 32'(busy_o[0]), 0);
    chk("abort_sel", 32'({sel_pc_o[0], sel_inc_o[0]}), 0);
    chk("abort_done", 32'(done_o[0]), 0);
    chk("abort_wrap", 32'(wrap_o[0]), 0);
    repeat (4) step();
    do_inc(0, S_A);

    // Settle of 4: load pulses while busy are dropped.
    do_load(1, 16'h0042, 1'b0);
    inc_i[1] = 1'b1;
    push_inc(1, S_B);
    step();
    inc_i[1]  = 1'b0;
    load_i[1] = 1'b1;
    data_i[1] = 16'hBEEF;
    repeat (S_B + 1) step();
    load_i[1] = 1'b0;
    step();
    do_inc(1, S_B);
    @(negedge clk);
    chk("b_pc_hold", 32'(pc_o[1]), 32'h0044);

    repeat (4) step();
    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
